press_event_gen: RTL

//   Consumes the debounced, clock-synchronous pushbutton level and turns it into events.

---
 rtl/press_event_if.sv | 21 ++
 rtl/press_event_gen.sv | 135 +++++++++++++
 2 files changed

// File: rtl/press_event_if.sv
// Button-event bundle: the debounced level in, registered event pulses and event count out.
// The DUT uses the slave modport; whatever drives the button level uses master.
interface press_event_if;
    logic       s_in;
    logic       press;
    logic       release_p;   // "release" is a reserved word, hence the suffix
    logic       long_press;
    logic       repeat_p;
    logic       held;
    logic [7:0] event_count;

    modport master (
        output s_in,
        input  press, release_p, long_press, repeat_p, held, event_count
    );

    modport slave (
        input  s_in,
        output press, release_p, long_press, repeat_p, held, event_count
    );
endinterface

// File: rtl/press_event_gen.sv
// Turns a debounced button level into press/release/long-press/auto-repeat pulses and an event count.
// Auto-repeat is built only when the macro PRESS_EVENT_REPEAT_EN is defined.
module press_event_gen #(
    parameter int LONG_CYCLES   = 8,
    parameter int REPEAT_CYCLES = 4,
    parameter int TW            = 8
) (
    input  logic           clk,
    input  logic           reset,
    press_event_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_ARM  = 2'b00,
        ST_IDLE = 2'b01,
        ST_HELD = 2'b10,
        ST_LONG = 2'b11
    } state_t;

    localparam logic [TW-1:0] LONG_TC = TW'(LONG_CYCLES - 1);

    if (LONG_CYCLES < 2 || LONG_CYCLES > 2**TW) begin : g_bad_long
        $error("press_event_gen: LONG_CYCLES=%0d outside 2..2**TW", LONG_CYCLES);
    end
    if (REPEAT_CYCLES < 1 || REPEAT_CYCLES > 2**TW) begin : g_bad_repeat
        $error("press_event_gen: REPEAT_CYCLES=%0d outside 1..2**TW", REPEAT_CYCLES);
    end

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic          held_q, held_d;
    logic [7:0]    count_q, count_d;

`ifdef PRESS_EVENT_REPEAT_EN
    localparam logic [TW-1:0] REPEAT_TC = TW'(REPEAT_CYCLES - 1);
    logic          repeat_q, repeat_d;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        count_d   = count_q;
`ifdef PRESS_EVENT_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        case (state_q)
            // A level still high out of reset must drop before any press can be accepted.
            ST_ARM: begin
                if (!bus.s_in) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.s_in) begin
                    press_d = 1'b1;
                    timer_d = '0;
                    count_d = count_q + 8'd1;
                    state_d = ST_HELD;
                end
            end
            ST_HELD: begin
                if (!bus.s_in) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (timer_q == LONG_TC) begin
                    long_d  = 1'b1;
                    timer_d = '0;
                    state_d = ST_LONG;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_LONG: begin
                if (!bus.s_in) begin
                    release_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
`ifdef PRESS_EVENT_REPEAT_EN
                    if (timer_q == REPEAT_TC) begin
                        repeat_d = 1'b1;
                        timer_d  = '0;
                        count_d  = count_q + 8'd1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
`endif
                end
            end
            default: state_d = ST_ARM;
        endcase
        // Stays up through the release pulse so consumers see held and release together.
        held_d = (state_d == ST_HELD) || (state_d == ST_LONG) || release_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_ARM;
            timer_q   <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            held_q    <= 1'b0;
            count_q   <= 8'd0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            held_q    <= held_d;
            count_q   <= count_d;
        end
    end

`ifdef PRESS_EVENT_REPEAT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) repeat_q <= 1'b0;
        else       repeat_q <= repeat_d;
    end
    assign bus.repeat_p = repeat_q;
`else
    assign bus.repeat_p = 1'b0;
`endif

    assign bus.press       = press_q;
    assign bus.release_p   = release_q;
    assign bus.long_press  = long_q;
    assign bus.held        = held_q;
    assign bus.event_count = count_q;

endmodule
